classifier_job_scheduler: RTL



---
 rtl/classifier_job_scheduler.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/classifier_job_scheduler.sv
// Round-robin scheduler sharing one transformer_classifier between NUM_REQ image sources.
// Define SCHED_TIMEOUT_EN to add the WAIT-state watchdog and the RECOVER path.
module classifier_job_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned IMAGE_SIZE     = 28,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned ID_W           = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] pix_data,
  input  logic [NUM_REQ-1:0]   pix_valid,
  output logic [NUM_REQ-1:0]   pix_ready,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 cls_ready,
  input  logic                 cls_done,
  input  logic [1:0]           cls_class,
  output logic                 cls_start,
  output logic [7:0]           cls_pixel,
  output logic                 cls_pixel_valid,
  output logic                 cls_rst,
  output logic                 res_valid,
  output logic [ID_W-1:0]      res_id,
  output logic [1:0]           res_class,
  output logic                 res_timeout,
  output logic                 busy
);

  localparam int unsigned     PIXELS    = IMAGE_SIZE * IMAGE_SIZE;
  localparam logic [15:0]     LAST_BEAT = 16'(PIXELS - 1);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_param_check
    $error("classifier_job_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT,
    S_RESULT
`ifdef SCHED_TIMEOUT_EN
    , S_RECOVER
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [15:0]          beat_q, beat_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   pix_ready_q, pix_ready_d;
  logic                 cls_start_q, cls_start_d;
  logic [7:0]           cls_pixel_q, cls_pixel_d;
  logic                 cls_pixel_valid_q, cls_pixel_valid_d;
  logic                 res_valid_q, res_valid_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic [1:0]           res_class_q, res_class_d;
  logic                 busy_q, busy_d;
  logic                 accept_c;
  logic                 arb_found;
  logic [ID_W-1:0]      arb_id;
  int unsigned          idx;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!arb_found && req[ID_W'(idx)]) begin
        arb_found = 1'b1;
        arb_id    = ID_W'(idx);
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_q, wd_d;
  logic        cls_rst_q, cls_rst_d;
  logic        res_timeout_q, res_timeout_d;
`endif

  always_comb begin
    state_d           = state_q;
    gnt_id_d          = gnt_id_q;
    rr_ptr_d          = rr_ptr_q;
    beat_d            = beat_q;
    cls_pixel_d       = cls_pixel_q;
    cls_pixel_valid_d = 1'b0;
    res_id_d          = res_id_q;
    res_class_d       = res_class_q;
`ifdef SCHED_TIMEOUT_EN
    wd_d          = wd_q;
    res_timeout_d = res_timeout_q;
`endif
    accept_c = (state_q == S_STREAM) && pix_valid[gnt_id_q] && pix_ready_q[gnt_id_q];

    case (state_q)
      S_IDLE: begin
        if (cls_ready && arb_found) begin
          gnt_id_d = arb_id;
          state_d  = S_START;
        end
      end
      S_START: begin
        beat_d  = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept_c) begin
          cls_pixel_d       = pix_data[{gnt_id_q, 3'b000} +: 8];
          cls_pixel_valid_d = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_WAIT;
`ifdef SCHED_TIMEOUT_EN
            wd_d    = '0;
`endif
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      S_WAIT: begin
        // A done arriving on the expiry cycle still counts as a normal result.
        if (cls_done) begin
          res_class_d = cls_class;
          state_d     = S_RESULT;
`ifdef SCHED_TIMEOUT_EN
          res_timeout_d = 1'b0;
        end else if (wd_q == WD_LAST) begin
          state_d = S_RECOVER;
        end else begin
          wd_d = wd_q + 16'd1;
`endif
        end
      end
      S_RESULT: begin
        rr_ptr_d = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + ID_W'(1);
        state_d  = S_IDLE;
      end
`ifdef SCHED_TIMEOUT_EN
      S_RECOVER: begin
        res_class_d   = 2'd0;
        res_timeout_d = 1'b1;
        state_d       = S_RESULT;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered.
    grant_d     = (state_d == S_IDLE) ? '0 : onehot(gnt_id_d);
    pix_ready_d = (state_d == S_STREAM) ? onehot(gnt_id_d) : '0;
    cls_start_d = (state_d == S_START);
    res_valid_d = (state_d == S_RESULT);
    busy_d      = (state_d != S_IDLE);
    if (state_d == S_RESULT) res_id_d = gnt_id_q;
`ifdef SCHED_TIMEOUT_EN
    cls_rst_d = (state_d == S_RECOVER);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      gnt_id_q          <= '0;
      rr_ptr_q          <= '0;
      beat_q            <= '0;
      grant_q           <= '0;
      pix_ready_q       <= '0;
      cls_start_q       <= 1'b0;
      cls_pixel_q       <= '0;
      cls_pixel_valid_q <= 1'b0;
      res_valid_q       <= 1'b0;
      res_id_q          <= '0;
      res_class_q       <= '0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      gnt_id_q          <= gnt_id_d;
      rr_ptr_q          <= rr_ptr_d;
      beat_q            <= beat_d;
      grant_q           <= grant_d;
      pix_ready_q       <= pix_ready_d;
      cls_start_q       <= cls_start_d;
      cls_pixel_q       <= cls_pixel_d;
      cls_pixel_valid_q <= cls_pixel_valid_d;
      res_valid_q       <= res_valid_d;
      res_id_q          <= res_id_d;
      res_class_q       <= res_class_d;
      busy_q            <= busy_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q          <= '0;
      cls_rst_q     <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      cls_rst_q     <= cls_rst_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign cls_rst     = cls_rst_q;
  assign res_timeout = res_timeout_q;
`else
  assign cls_rst     = 1'b0;
  assign res_timeout = 1'b0;
`endif

  assign grant           = grant_q;
  assign pix_ready       = pix_ready_q;
  assign cls_start       = cls_start_q;
  assign cls_pixel       = cls_pixel_q;
  assign cls_pixel_valid = cls_pixel_valid_q;
  assign res_valid       = res_valid_q;
  assign res_id          = res_id_q;
  assign res_class       = res_class_q;
  assign busy            = busy_q;

endmodule
